// File: rtl/dwbuart_pkg.sv
// Shared constants for the UART sequencer: register map, status bits and FSM encoding.
package dwbuart_pkg;

    localparam logic [31:0] UART_CR   = 32'h0;
    localparam logic [31:0] UART_SR   = 32'h4;
    localparam logic [31:0] UART_RXDR = 32'h8;
    localparam logic [31:0] UART_TXDR = 32'hC;

    localparam int SR_RXNE = 0;
    localparam int SR_TXE  = 1;
    localparam int SR_RXOE = 2;
    localparam int SR_FE   = 3;
    localparam int SR_PE   = 4;

    typedef enum logic [3:0] {
        ST_CFG_REQ   = 4'd0,
        ST_CFG_WAIT  = 4'd1,
        ST_POLL_REQ  = 4'd2,
        ST_POLL_WAIT = 4'd3,
        ST_RX_REQ    = 4'd4,
        ST_RX_WAIT   = 4'd5,
        ST_TX_REQ    = 4'd6,
        ST_TX_WAIT   = 4'd7,
        ST_POLL_GAP  = 4'd8
    } seq_state_t;

endpackage

// File: rtl/dwbuart_wb_master.sv
// Single-outstanding pipelined Wishbone master; done or timeout pulses one cycle after the bus cycle ends.
module dwbuart_wb_master
    import dwbuart_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    logic [9:0] ack_cnt_reg;
    logic       accept;

    // An ack only counts once the strobe has been (or is being) accepted.
    assign accept   = wb_cyc_o && (!wb_stb_o || !wb_stall_i);
    assign wb_sel_o = 4'hF;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            ack_cnt_reg <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            rdata       <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (!wb_cyc_o) begin
                if (req) begin
                    wb_cyc_o    <= 1'b1;
                    wb_stb_o    <= 1'b1;
                    wb_we_o     <= we;
                    wb_adr_o    <= adr;
                    wb_dat_o    <= wdata;
                    ack_cnt_reg <= '0;
                end
            end else if (accept) begin
                wb_stb_o <= 1'b0;
                if (wb_ack_i) begin
                    wb_cyc_o <= 1'b0;
                    done     <= 1'b1;
                    rdata    <= wb_dat_i;
                end else if (!wb_stb_o) begin
                    if (ack_cnt_reg == 10'(ACK_TIMEOUT - 1)) begin
                        wb_cyc_o <= 1'b0;
                        timeout  <= 1'b1;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + 10'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dwbuart_seq.sv
// Sequencer that configures the UART, polls SR and moves bytes between RXDR/TXDR and byte streams.
module dwbuart_seq
    import dwbuart_pkg::*;
#(
    parameter int POLL_GAP    = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] cfg_cr_i,
    input  logic        cfg_start_i,
    output logic        cfg_done_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [3:0]  err_o,
    input  logic        err_clr_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    seq_state_t  state_reg;
    seq_state_t  after_idle;
    logic [7:0]  gap_cnt_reg;
    logic        cfg_pending_reg, cfg_done_reg, rx_valid_reg, tx_ready_reg;
    logic [7:0]  rx_data_reg;
    logic [3:0]  err_reg, err_next;
    logic        m_req, m_we, m_done, m_timeout;
    logic [31:0] m_adr, m_wdata, m_rdata;
    logic        is_wait, xfer_end, cfg_take;
    logic        unused_rdata;

    assign unused_rdata = ^m_rdata[31:8];
    assign after_idle   = (POLL_GAP == 0) ? ST_POLL_REQ : ST_POLL_GAP;
    assign xfer_end     = m_done | m_timeout;
    assign is_wait      = (state_reg == ST_CFG_WAIT) || (state_reg == ST_POLL_WAIT) ||
                          (state_reg == ST_RX_WAIT)  || (state_reg == ST_TX_WAIT);
    // A reconfiguration request never interrupts a bus cycle in flight.
    assign cfg_take     = (cfg_pending_reg | cfg_start_i) &
                          ((state_reg == ST_POLL_GAP) | (is_wait & xfer_end));

    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_adr   = UART_SR;
        m_wdata = '0;
        case (state_reg)
            ST_CFG_REQ:  begin m_req = 1'b1; m_we = 1'b1; m_adr = UART_CR; m_wdata = cfg_cr_i; end
            ST_POLL_REQ: begin m_req = 1'b1; m_adr = UART_SR; end
            ST_RX_REQ:   begin m_req = 1'b1; m_adr = UART_RXDR; end
            ST_TX_REQ:   begin m_req = 1'b1; m_we = 1'b1; m_adr = UART_TXDR; m_wdata = {24'b0, tx_data_i}; end
            default:     ;
        endcase
    end

    always_comb begin
        err_next = err_clr_i ? 4'b0 : err_reg;
        if (is_wait && m_timeout)
            err_next[3] = 1'b1;
        if (state_reg == ST_POLL_WAIT && m_done)
            err_next[2:0] = err_next[2:0] | {m_rdata[SR_PE], m_rdata[SR_FE], m_rdata[SR_RXOE]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= ST_CFG_REQ;
            gap_cnt_reg     <= '0;
            cfg_pending_reg <= 1'b0;
            cfg_done_reg    <= 1'b0;
            rx_valid_reg    <= 1'b0;
            rx_data_reg     <= '0;
            tx_ready_reg    <= 1'b0;
            err_reg         <= '0;
        end else begin
            tx_ready_reg <= 1'b0;
            err_reg      <= err_next;
            if (rx_valid_reg && rx_ready_i)
                rx_valid_reg <= 1'b0;
            if (cfg_take)
                cfg_pending_reg <= 1'b0;
            else if (cfg_start_i)
                cfg_pending_reg <= 1'b1;
            if (cfg_start_i)
                cfg_done_reg <= 1'b0;
            if (state_reg != ST_POLL_GAP)
                gap_cnt_reg <= '0;

            case (state_reg)
                ST_CFG_REQ:  state_reg <= ST_CFG_WAIT;
                ST_POLL_REQ: state_reg <= ST_POLL_WAIT;
                ST_RX_REQ:   state_reg <= ST_RX_WAIT;
                ST_TX_REQ:   state_reg <= ST_TX_WAIT;
                ST_CFG_WAIT: begin
                    if (m_done) begin
                        if (!cfg_take)
                            cfg_done_reg <= 1'b1;
                        state_reg <= ST_POLL_REQ;
                    end else if (m_timeout) begin
                        state_reg <= after_idle;
                    end
                end
                ST_POLL_WAIT: begin
                    if (m_done) begin
                        if (m_rdata[SR_RXNE] && !rx_valid_reg)
                            state_reg <= ST_RX_REQ;
                        else if (m_rdata[SR_TXE] && tx_valid_i)
                            state_reg <= ST_TX_REQ;
                        else
                            state_reg <= after_idle;
                    end else if (m_timeout) begin
                        state_reg <= after_idle;
                    end
                end
                ST_RX_WAIT: begin
                    if (m_done) begin
                        rx_data_reg  <= m_rdata[7:0];
                        rx_valid_reg <= 1'b1;
                        state_reg    <= ST_POLL_REQ;
                    end else if (m_timeout) begin
                        state_reg <= after_idle;
                    end
                end
                ST_TX_WAIT: begin
                    if (m_done) begin
                        tx_ready_reg <= 1'b1;
                        state_reg    <= ST_POLL_REQ;
                    end else if (m_timeout) begin
                        state_reg <= after_idle;
                    end
                end
                ST_POLL_GAP: begin
                    if (gap_cnt_reg == 8'(POLL_GAP - 1))
                        state_reg <= ST_POLL_REQ;
                    else
                        gap_cnt_reg <= gap_cnt_reg + 8'd1;
                end
                default: state_reg <= ST_CFG_REQ;
            endcase

            if (cfg_take)
                state_reg <= ST_CFG_REQ;
        end
    end

    assign cfg_done_o = cfg_done_reg;
    assign rx_valid_o = rx_valid_reg;
    assign rx_data_o  = rx_data_reg;
    assign tx_ready_o = tx_ready_reg;
    assign err_o      = err_reg;

    dwbuart_wb_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wb_master (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req        (m_req),
        .we         (m_we),
        .adr        (m_adr),
        .wdata      (m_wdata),
        .done       (m_done),
        .rdata      (m_rdata),
        .timeout    (m_timeout),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_ack_i   (wb_ack_i),
        .wb_stall_i (wb_stall_i)
    );

endmodule

// File: tb/tb_dwbuart_seq.sv
// Directed bench for dwbuart_seq with a small UART slave responder and a transaction log.
module tb_dwbuart_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] cfg_cr_i;
    logic        cfg_start_i, cfg_done_o;
    logic [7:0]  tx_data_i, rx_data_o;
    logic        tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
    logic [3:0]  err_o, wb_sel_o;
    logic        err_clr_i;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_stall_i = 1'b0;

    always #5 clk_i = ~clk_i;

    dwbuart_seq #(.POLL_GAP(4), .ACK_TIMEOUT(255)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_cr_i(cfg_cr_i), .cfg_start_i(cfg_start_i),
        .cfg_done_o(cfg_done_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .err_o(err_o), .err_clr_i(err_clr_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave responder, driven on the falling edge; every acked access is logged.
    logic [31:0] sr_val, rxdr_val;
    int          ack_delay, stall_arm, wait_cnt, sr_acks;
    bit          no_ack;
    logic [31:0] log_adr [2048];
    logic [31:0] log_dat [2048];
    logic        log_we  [2048];
    int          log_cyc [2048];
    int          n_log = 0;
    int          cyc_cnt = 0;

    initial begin
        wait_cnt = 0;
        sr_acks  = 0;
    end

    always @(posedge clk_i) cyc_cnt++;

    task automatic do_ack();
        wb_ack_i = 1'b1;
        wb_dat_i = (wb_adr_o == 32'h4) ? sr_val : (wb_adr_o == 32'h8) ? rxdr_val : 32'h0;
        if (wb_adr_o == 32'h4) sr_acks++;
        if (n_log < 2048) begin
            log_adr[n_log] = wb_adr_o;
            log_we[n_log]  = wb_we_o;
            log_dat[n_log] = wb_we_o ? wb_dat_o : wb_dat_i;
            log_cyc[n_log] = cyc_cnt;
            n_log++;
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            wb_ack_i   = 1'b0;
            wb_stall_i = 1'b0;
            wait_cnt   = 0;
        end else begin
            wb_ack_i   = 1'b0;
            wb_stall_i = 1'b0;
            if (wb_cyc_o && wb_stb_o) begin
                if (stall_arm > 0 && wb_adr_o == 32'hC) begin
                    wb_stall_i = 1'b1;
                    stall_arm--;
                end else if (ack_delay == 0 && !no_ack) begin
                    do_ack();
                end else begin
                    wait_cnt = ack_delay;
                end
            end else if (wb_cyc_o && wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0 && !no_ack) do_ack();
            end
        end
    end

    // Bus monitors: TXDR strobe cycles and length of the post-accept wait.
    int stb_c = 0, dat_bad = 0, run = 0, last_run = 0;
    always @(negedge clk_i) begin
        if (wb_cyc_o && wb_stb_o && wb_adr_o == 32'hC) begin
            stb_c++;
            if (wb_dat_o !== 32'h3C || wb_we_o !== 1'b1) dat_bad++;
        end
        if (wb_cyc_o && !wb_stb_o) run++;
        else begin
            if (run > 0) last_run = run;
            run = 0;
        end
    end

    function automatic int find_adr(input int from, input logic [31:0] a);
        for (int i = from; i < n_log; i++)
            if (log_adr[i] == a) return i;
        return -1;
    endfunction

    function automatic int count_adr(input int from, input logic [31:0] a);
        int c = 0;
        for (int i = from; i < n_log; i++)
            if (log_adr[i] == a) c++;
        return c;
    endfunction

    function automatic logic [31:0] get_dat(input int idx);
        if (idx < 0) return 'x;
        return log_dat[idx];
    endfunction

    // Returns once a fresh SR poll has been decided, so the FSM is idling in the gap.
    task automatic wait_idle_poll();
        int n0 = sr_acks;
        for (int k = 0; k < 100 && sr_acks == n0; k++) @(negedge clk_i);
        chk("poll_seen", 32'(sr_acks > n0), 1);
        repeat (2) @(negedge clk_i);
    endtask

    int base, ri, ti, ci, n0;
    bit seen;

    initial begin
        cfg_cr_i = 32'h0364_0002; cfg_start_i = 0; tx_data_i = 0; tx_valid_i = 0;
        rx_ready_i = 0; err_clr_i = 0;
        sr_val = 32'h2; rxdr_val = 0; ack_delay = 1; stall_arm = 0; no_ack = 0;

        // Reset values
        repeat (3) @(negedge clk_i);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_sel", wb_sel_o, 4'hF);
        chk("rst_cfg_done", cfg_done_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_rx_data", rx_data_o, 0);
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_err", err_o, 0);
        rst_ni = 1;
        @(negedge clk_i);
        chk("cfg_done_before_cr", cfg_done_o, 0);

        // Configuration write followed by the first SR poll
        for (int k = 0; k < 50 && n_log < 2; k++) @(negedge clk_i);
        chk("cr_adr", log_adr[0], 32'h0);
        chk("cr_we", log_we[0], 1);
        chk("cr_dat", log_dat[0], 32'h0364_0002);
        chk("sr_adr", log_adr[1], 32'h4);
        chk("sr_we", log_we[1], 0);
        chk("cfg_done_set", cfg_done_o, 1);

        // RX has priority over TX
        wait_idle_poll();
        base = n_log; rxdr_val = 32'hA5; tx_data_i = 8'h5A; tx_valid_i = 1; sr_val = 32'h3;
        for (int k = 0; k < 100 && !tx_ready_o; k++) @(negedge clk_i);
        chk("tx_ready_seen", tx_ready_o, 1);
        tx_valid_i = 0;
        ri = find_adr(base, 32'h8);
        ti = find_adr(base, 32'hC);
        chk("rx_before_tx", 32'(ri >= 0 && ti > ri), 1);
        chk("txdr_dat", get_dat(ti), 32'h5A);
        chk("rx_data", rx_data_o, 8'hA5);
        chk("rx_valid", rx_valid_o, 1);
        @(negedge clk_i);
        chk("tx_ready_pulse", tx_ready_o, 0);

        // Unconsumed RX byte blocks further RXDR reads; idle poll spacing
        sr_val = 32'h1; base = n_log;
        repeat (120) @(negedge clk_i);
        chk("no_rx_reread", count_adr(base, 32'h8), 0);
        chk("rx_held", rx_valid_o, 1);
        chk("last_three_sr", 32'(log_adr[n_log-1] == 4 && log_adr[n_log-2] == 4 && log_adr[n_log-3] == 4), 1);
        chk("poll_gap_a", log_cyc[n_log-1] - log_cyc[n_log-2], 8);
        chk("poll_gap_b", log_cyc[n_log-2] - log_cyc[n_log-3], 8);

        // Overrun reported, then cleared
        sr_val = 32'h5;
        for (int k = 0; k < 40 && err_o == 0; k++) @(negedge clk_i);
        chk("err_rxoe", err_o, 4'b0001);
        sr_val = 32'h1;
        err_clr_i = 1; @(negedge clk_i); err_clr_i = 0;
        chk("err_cleared", err_o, 0);

        // A set in the same cycle as a held clear wins
        sr_val = 32'h5; err_clr_i = 1; seen = 0;
        repeat (24) begin
            @(negedge clk_i);
            if (err_o != 0) seen = 1;
        end
        err_clr_i = 0; sr_val = 32'h1;
        chk("set_wins_over_clr", 32'(seen), 1);
        repeat (3) @(negedge clk_i);
        err_clr_i = 1; @(negedge clk_i); err_clr_i = 0;
        chk("err_cleared2", err_o, 0);

        // Consume the RX byte
        sr_val = 32'h2;
        repeat (20) @(negedge clk_i);
        rx_ready_i = 1; @(negedge clk_i); rx_ready_i = 0;
        chk("rx_consumed", rx_valid_o, 0);

        // Stalled TXDR write
        wait_idle_poll();
        base = n_log; stb_c = 0; dat_bad = 0; stall_arm = 3; tx_data_i = 8'h3C; tx_valid_i = 1;
        for (int k = 0; k < 100 && !tx_ready_o; k++) @(negedge clk_i);
        chk("stall_tx_ready", tx_ready_o, 1);
        tx_valid_i = 0;
        chk("stall_stb_cycles", stb_c, 4);
        chk("stall_dat_stable", dat_bad, 0);
        repeat (40) @(negedge clk_i);
        chk("stall_one_write", count_adr(base, 32'hC), 1);
        chk("stall_txdr_dat", get_dat(find_adr(base, 32'hC)), 32'h3C);

        // Ack timeout on an SR read
        wait_idle_poll();
        no_ack = 1; last_run = 0;
        for (int k = 0; k < 400 && !err_o[3]; k++) @(negedge clk_i);
        no_ack = 0;
        chk("timeout_err", err_o, 4'b1000);
        chk("timeout_len", last_run, 255);
        chk("timeout_cyc_low", wb_cyc_o, 0);
        n0 = sr_acks;
        for (int k = 0; k < 30 && sr_acks == n0; k++) @(negedge clk_i);
        chk("poll_resumes", 32'(sr_acks > n0), 1);
        err_clr_i = 1; @(negedge clk_i); err_clr_i = 0;

        // cfg_start during an outstanding RXDR read
        wait_idle_poll();
        cfg_cr_i = 32'h0000_1234; ack_delay = 3; rxdr_val = 32'h77; sr_val = 32'h1; base = n_log;
        for (int k = 0; k < 60 && !(wb_cyc_o && wb_adr_o == 32'h8); k++) @(negedge clk_i);
        chk("rx_cycle_seen", 32'(wb_cyc_o && wb_adr_o == 32'h8), 1);
        cfg_start_i = 1; @(negedge clk_i); cfg_start_i = 0;
        chk("cfg_done_dropped", cfg_done_o, 0);
        for (int k = 0; k < 80 && find_adr(base, 32'h0) < 0; k++) @(negedge clk_i);
        ri = find_adr(base, 32'h8);
        ci = find_adr(base, 32'h0);
        chk("rx_then_cr", 32'(ri >= 0 && ci == ri + 1), 1);
        chk("cr_rewrite_dat", get_dat(ci), 32'h0000_1234);
        chk("rx_data2", rx_data_o, 8'h77);
        repeat (10) @(negedge clk_i);
        chk("cfg_done_again", cfg_done_o, 1);

        // Reset in the middle of a bus cycle
        for (int k = 0; k < 60 && !wb_cyc_o; k++) @(negedge clk_i);
        chk("cyc_before_rst", wb_cyc_o, 1);
        #2 rst_ni = 0;
        #1;
        chk("mid_rst_cyc", wb_cyc_o, 0);
        chk("mid_rst_stb", wb_stb_o, 0);
        chk("mid_rst_cfg_done", cfg_done_o, 0);
        chk("mid_rst_rx_valid", rx_valid_o, 0);
        @(negedge clk_i);
        #1;
        ack_delay = 1; base = n_log; rst_ni = 1;
        for (int k = 0; k < 40 && n_log == base; k++) @(negedge clk_i);
        chk("restart_adr", log_adr[base], 32'h0);
        chk("restart_dat", log_dat[base], 32'h0000_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwbuart_seq.md
Name: dwbuart_seq

Overview:
- Wishbone master that drives the ecap5_dwbuart slave port so logic-side clients can move bytes through it without a CPU.
- After reset and on each cfg_start_i, writes a configuration word to CR. After that it polls SR, drains RXDR into an RX byte stream and feeds a TX byte stream into TXDR.
- Sits between the UART slave and hardware producers/consumers (loopback, debug console, boot loader).

Parameters:
POLL_GAP, 4, idle cycles inserted between consecutive SR polls when no transfer happened (0..255)
ACK_TIMEOUT, 255, cycles waited for wb_ack_i after the strobe is accepted before the cycle is aborted (1..1023)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_cr_i  in  32  word written verbatim to CR
cfg_start_i  in  1  pulse: (re)write CR at the next sequencing point
cfg_done_o  out  1  high once CR has been written since the last reset or cfg_start_i
tx_data_i  in  8  byte to transmit
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  one-cycle pulse: byte consumed (TXDR write acked)
rx_data_o  out  8  received byte
rx_valid_o  out  1  rx_data_o valid; held until rx_ready_i
rx_ready_i  in  1  consumer accepts rx_data_o
err_o  out  4  sticky {timeout, pe, fe, rxoe}
err_clr_i  in  1  clears err_o
wb_adr_o  out  32  register address
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte select, always 4'hF
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  acknowledge
wb_stall_i  in  1  stall

Behaviour:
- Reset (async, rst_ni low): state CFG_REQ. All wb_* outputs 0 except wb_sel_o=4'hF. cfg_done_o=0, rx_valid_o=0, rx_data_o=0, tx_ready_o=0, err_o=0. The poll gap and timeout counters are cleared.
- Bus access (pipelined, one outstanding transaction):
  - REQ state: cyc=stb=1 with address, we and data.
  - stb drops in the first cycle with stall=0.
  - cyc stays high until ack, then drops in the following cycle.
  - An ack in the same cycle as the accepted strobe is legal and completes the access.
- Timeout: after acceptance, an ack counter counts cycles. When it reaches ACK_TIMEOUT: cyc=0, err_o[3]=1, any read result is discarded, and the FSM goes to POLL_GAP.
- States:
  - CFG_REQ/CFG_WAIT: write cfg_cr_i to CR. On ack, cfg_done_o=1 -> POLL_REQ.
  - POLL_REQ/POLL_WAIT: read SR. On ack, latch SR.
    - OR bits pe/fe/rxoe into err_o.
    - If RXNE=1 and rx_valid_o=0 -> RX_REQ.
    - Else if TXE=1 and tx_valid_i -> TX_REQ.
    - Else -> POLL_GAP.
  - RX_REQ/RX_WAIT: read RXDR. On ack, rx_data_o=wb_dat_i[7:0], rx_valid_o=1 -> POLL_REQ (no gap).
  - TX_REQ/TX_WAIT: write {24'b0,tx_data_i} to TXDR. tx_data_i is sampled at TX_REQ entry and must stay stable until tx_ready_o. On ack, tx_ready_o=1 for one cycle -> POLL_REQ.
  - POLL_GAP: count POLL_GAP cycles (0 means none) -> POLL_REQ.
- cfg_start_i: recorded in a pending flag, cfg_done_o=0. It is taken only from POLL_GAP or on leaving a WAIT state (never mid-bus-cycle), and redirects to CFG_REQ.
- RX takes priority over TX. An unconsumed RX byte blocks further RX reads; the UART's own overrun flag (rxoe) is then reported through err_o.
- rx handshake: rx_valid_o clears in the cycle after rx_valid_o & rx_ready_i.
- err_clr_i clears err_o. If an error sets in the same cycle as the clear, the set wins.
- Reset mid-bus-cycle drops cyc/stb immediately. A transaction abandoned this way is not retried; the FSM restarts at CFG_REQ.

Decomposition:
- Package dwbuart_pkg:
  - Register offsets UART_CR=32'h0, UART_SR=32'h4, UART_RXDR=32'h8, UART_TXDR=32'hC.
  - SR bit positions SR_RXNE=0, SR_TXE=1, SR_RXOE=2, SR_FE=3, SR_PE=4.
  - State enum seq_state_t.
- Sub-module dwbuart_wb_master: single-transaction pipelined Wishbone engine with the timeout counter. Interface: req/we/adr/wdata in, done/rdata/timeout out. dwbuart_seq holds the sequencing FSM only.

Test Plan:
- Reset release, cfg_cr_i=32'h0364_0002, slave acks 1 cycle after accept -> one write to adr 0x0 with data 32'h0364_0002, then cfg_done_o=1, then a read of 0x4.
- SR returns 32'h3 (RXNE, TXE), RXDR returns 8'hA5, tx_valid_i=1 with tx_data_i=8'h5A -> RXDR read before TXDR write. rx_data_o=8'hA5, rx_valid_o=1. TXDR write data 32'h5A, tx_ready_o one pulse.
- rx_ready_i held 0, SR always 32'h1 -> no second RXDR read; SR polls separated by POLL_GAP+overhead cycles. Then SR=32'h5 sets err_o=4'b0001, cleared by err_clr_i.
- wb_stall_i high for 3 cycles on the TXDR write -> stb held with stable adr/dat for 4 cycles, stall never drops the request, exactly one write completes.
- Slave never acks an SR read -> cyc drops after ACK_TIMEOUT=255 cycles, err_o[3]=1, polling resumes after the gap.
- cfg_start_i pulsed during an outstanding RXDR read -> the read completes, then CR is rewritten, cfg_done_o 0 then 1. rst_ni asserted mid-cycle -> cyc=stb=0 in the same cycle.
